// File: rtl/hf_subcarrier_rx.sv
// hf_subcarrier_rx: edge-filtered subcarrier detector with SSP bit serialiser
module hf_subcarrier_rx #(
  parameter int         ADC_W       = 8,
  parameter int         WIN_LOG2    = 4,
  parameter int         FRAME_LOG2  = 3,
  parameter logic [2:0] LISTEN_MODE = 3'b011
) (
  input  logic                ck_1356meg,
  input  logic                rst,
  input  logic [ADC_W-1:0]    adc_d,
  input  logic [2:0]          mod_type,
  input  logic [ADC_W+1:0]    edge_threshold,
  input  logic [WIN_LOG2-1:0] reset_phase,
  output logic                curbit,
  output logic                bit_valid,
  output logic                ssp_clk,
  output logic                ssp_frame,
  output logic                ssp_din
);
  localparam int CW = WIN_LOG2 + FRAME_LOG2;
  localparam int YW = ADC_W + 3;
  localparam logic [CW-1:0] FR_ON = CW'(2**(WIN_LOG2-1) - 1);
  localparam logic [CW-1:0] FR_OFF = CW'(2**WIN_LOG2 + 2**(WIN_LOG2-1) - 1);
  localparam logic [WIN_LOG2-1:0] PH_HALF = WIN_LOG2'(2**(WIN_LOG2-1));
  logic [CW-1:0] r_cnt;
  logic [ADC_W-1:0] r_x1, r_x2, r_x3, r_x4;
  logic signed [YW-1:0] r_fall_max, r_rise_min;
  logic r_curbit, r_bit_valid, r_ssp_clk, r_ssp_frame, r_sendbit, r_ssp_din;
  logic [WIN_LOG2-1:0] w_ph;
  logic signed [YW-1:0] w_y, w_thr, w_nthr;
  logic w_resolve;
  assign w_ph = r_cnt[WIN_LOG2-1:0];
  assign w_y = $signed({2'b00, r_x4, 1'b0}) + $signed({3'b000, r_x3})
             - $signed({2'b00, adc_d, 1'b0}) - $signed({3'b000, r_x1});
  assign w_thr = $signed({1'b0, edge_threshold});
  assign w_nthr = -w_thr;
  assign w_resolve = w_ph == reset_phase;
  assign curbit = r_curbit;
  assign bit_valid = r_bit_valid;
  assign ssp_clk = r_ssp_clk;
  assign ssp_frame = r_ssp_frame;
  assign ssp_din = r_ssp_din;
  // free-running sample counter and four-deep sample history
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_cnt <= '0;
      {r_x1, r_x2, r_x3, r_x4} <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      {r_x1, r_x2, r_x3, r_x4} <= {adc_d, r_x1, r_x2, r_x3};
    end
  end
  // track strongest edges each window and resolve the bit at reset_phase
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_fall_max <= '0;
      r_rise_min <= '0;
      r_curbit <= 1'b0;
      r_bit_valid <= 1'b0;
    end else if (w_resolve) begin
      r_curbit <= (r_fall_max > w_thr) && (r_rise_min < w_nthr);
      r_fall_max <= '0;
      r_rise_min <= '0;
      r_bit_valid <= 1'b1;
    end else begin
      r_fall_max <= w_y > r_fall_max ? w_y : r_fall_max;
      r_rise_min <= w_y < r_rise_min ? w_y : r_rise_min;
      r_bit_valid <= 1'b0;
    end
  end
  // SSP clock, frame and data towards the ARM
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      r_ssp_clk <= 1'b0;
      r_ssp_frame <= 1'b0;
      r_sendbit <= 1'b0;
      r_ssp_din <= 1'b0;
    end else begin
      r_ssp_clk <= w_ph == '0 ? 1'b1 : w_ph == PH_HALF ? 1'b0 : r_ssp_clk;
      r_ssp_frame <= r_cnt == FR_ON ? 1'b1 : r_cnt == FR_OFF ? 1'b0 : r_ssp_frame;
      r_sendbit <= w_ph == '0 ? (mod_type == LISTEN_MODE) && r_curbit : r_sendbit;
      r_ssp_din <= r_sendbit;
    end
  end
endmodule
